// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps a phase index 0..NUM_PHASES-1 under
// run/stop and single-step push-buttons, counting retired instructions.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             step,
  input  logic             stall,
  input  logic             halt,
  output logic [3:0]       phase,
  output logic             phase_valid,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASES - 1);
  localparam logic [3:0] PHASE_LIM  = 4'(NUM_PHASES);

  state_t           r_state;
  logic [3:0]       r_phase;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic             r_exec_s1, r_exec_s2, r_exec_prev;
  logic             r_step_s1, r_step_s2, r_step_prev;

  state_t     w_state_nxt;
  logic [3:0] w_phase_nxt;
  logic       w_done_nxt;
  logic       w_cnt_inc;
  logic       w_exec_rise;
  logic       w_step_rise;
  logic       w_wrap;

  // Button levels are asynchronous: two-flop synchroniser, then edge detect.
  assign w_exec_rise = r_exec_s2 & ~r_exec_prev;
  assign w_step_rise = r_step_s2 & ~r_step_prev;
  assign w_wrap      = (r_phase == LAST_PHASE);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_done_nxt  = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_exec_rise)      w_state_nxt = S_RUN;
        else if (w_step_rise) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        // A stop request freezes the phase, even on the last phase.
        if (w_exec_rise) begin
          w_state_nxt = S_IDLE;
        end else if (!stall) begin
          if (w_wrap) begin
            w_phase_nxt = 4'd0;
            w_done_nxt  = 1'b1;
            w_cnt_inc   = 1'b1;
            if (halt) w_state_nxt = S_HALTED;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
      end
      S_STEP: begin
        w_state_nxt = S_IDLE;
        if (w_wrap) begin
          w_phase_nxt = 4'd0;
          w_done_nxt  = 1'b1;
          w_cnt_inc   = 1'b1;
          if (halt) w_state_nxt = S_HALTED;
        end else begin
          w_phase_nxt = r_phase + 4'd1;
        end
      end
      S_HALTED: w_phase_nxt = 4'd0;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (r_phase >= PHASE_LIM) begin
      w_phase_nxt = 4'd0;
      w_done_nxt  = 1'b0;
      w_cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= 4'd0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_exec_s1   <= 1'b0;
      r_exec_s2   <= 1'b0;
      r_exec_prev <= 1'b0;
      r_step_s1   <= 1'b0;
      r_step_s2   <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_done      <= w_done_nxt;
      if (w_cnt_inc) r_count <= r_count + 1'b1;
      r_exec_s1   <= exec;
      r_exec_s2   <= r_exec_s1;
      r_exec_prev <= r_exec_s2;
      r_step_s1   <= step;
      r_step_s2   <= r_step_s1;
      r_step_prev <= r_step_s2;
    end
  end

  assign phase       = r_phase;
  assign phase_valid = (r_state == S_RUN) || (r_state == S_STEP);
  assign instr_done  = r_done;
  assign halted      = (r_state == S_HALTED);
  assign instr_count = r_count;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a per-cycle vector table for the
// basic run sequence, then hand sequences for stall, stop/resume, step, halt and count wrap.
module tb_phase_sequencer;

  localparam int NP = 5;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          exec  = 1'b0;
  logic          step  = 1'b0;
  logic          stall = 1'b0;
  logic          halt  = 1'b0;
  logic [3:0]    phase;
  logic          phase_valid;
  logic          instr_done;
  logic          halted;
  logic [CW-1:0] instr_count;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .exec        (exec),
    .step        (step),
    .stall       (stall),
    .halt        (halt),
    .phase       (phase),
    .phase_valid (phase_valid),
    .instr_done  (instr_done),
    .halted      (halted),
    .instr_count (instr_count),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, ex, st, sl, hl;
    logic [3:0] ph;
    logic       vld, dn, hlt;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exec_pulse();
    exec = 1'b1;
    tick(); tick(); tick();
    exec = 1'b0;
  endtask

  initial begin
    // Reset, then exec held three cycles: RUN entered on the third edge.
    tbl[0] = '{1,0,0,0,0, 0, 0,0,0, 0};
    tbl[1] = '{0,1,0,0,0, 0, 0,0,0, 0};
    tbl[2] = '{0,1,0,0,0, 0, 0,0,0, 0};
    tbl[3] = '{0,1,0,0,0, 0, 1,0,0, 0};
    tbl[4] = '{0,0,0,0,0, 1, 1,0,0, 0};
    tbl[5] = '{0,0,0,0,0, 2, 1,0,0, 0};
    tbl[6] = '{0,0,0,0,0, 3, 1,0,0, 0};
    tbl[7] = '{0,0,0,0,0, 4, 1,0,0, 0};
    tbl[8] = '{0,0,0,0,0, 0, 1,1,0, 1};
    tbl[9] = '{0,0,0,0,0, 1, 1,0,0, 1};

    tick();
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; exec = tbl[i].ex; step = tbl[i].st;
      stall = tbl[i].sl;  halt = tbl[i].hl;
      tick();
      chk($sformatf("vec%0d_phase", i), int'(phase), int'(tbl[i].ph));
      chk($sformatf("vec%0d_valid", i), int'(phase_valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d_done", i), int'(instr_done), int'(tbl[i].dn));
      chk($sformatf("vec%0d_halted", i), int'(halted), int'(tbl[i].hlt));
      chk($sformatf("vec%0d_count", i), int'(instr_count), int'(tbl[i].cnt));
    end

    // Stall holds phase 2, then resumes to 3.
    tick();
    chk("pre_stall_phase", int'(phase), 2);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_phase", int'(phase), 2);
      chk("stall_done", int'(instr_done), 0);
    end
    stall = 1'b0;
    tick();
    chk("stall_resume_phase", int'(phase), 3);

    // Stop at phase 3 (stall keeps it there while exec syncs), then resume.
    stall = 1'b1;
    exec_pulse();
    stall = 1'b0;
    chk("stop_phase", int'(phase), 3);
    chk("stop_valid", int'(phase_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_phase", int'(phase), 3);
      chk("idle_valid", int'(phase_valid), 0);
    end
    exec_pulse();
    chk("resume_valid", int'(phase_valid), 1);
    chk("resume_phase", int'(phase), 3);
    tick();
    chk("resume_p4", int'(phase), 4);
    tick();
    chk("resume_wrap_phase", int'(phase), 0);
    chk("resume_wrap_done", int'(instr_done), 1);
    chk("resume_wrap_count", int'(instr_count), 2);

    // Single-step five phases from reset.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step = 1'b1;
      tick(); tick(); tick();
      step = 1'b0;
      chk("step_valid_on", int'(phase_valid), 1);
      chk("step_phase_before", int'(phase), k - 1);
      tick();
      chk("step_phase_after", int'(phase), k % NP);
      chk("step_valid_off", int'(phase_valid), 0);
      chk("step_done", int'(instr_done), (k == 5) ? 1 : 0);
      tick(); tick();
    end
    chk("step_count", int'(instr_count), 1);

    // Simultaneous exec and step rise: exec wins, sequencer keeps running.
    reset = 1'b1; tick(); reset = 1'b0;
    exec = 1'b1; step = 1'b1;
    tick(); tick(); tick();
    exec = 1'b0; step = 1'b0;
    chk("both_valid", int'(phase_valid), 1);
    tick();
    chk("both_run_phase", int'(phase), 1);
    chk("both_run_valid", int'(phase_valid), 1);

    // Halt only takes effect at the 4->0 wrap.
    reset = 1'b1; tick(); reset = 1'b0;
    exec_pulse();
    tick();
    chk("halt_p1", int'(phase), 1);
    halt = 1'b1;
    for (int p = 2; p <= 4; p++) begin
      tick();
      chk("halt_ignored_phase", int'(phase), p);
      chk("halt_ignored_halted", int'(halted), 0);
    end
    tick();
    halt = 1'b0;
    chk("halt_phase", int'(phase), 0);
    chk("halt_halted", int'(halted), 1);
    chk("halt_done", int'(instr_done), 1);
    chk("halt_count", int'(instr_count), 1);
    exec_pulse();
    tick(); tick();
    chk("halt_exec_ignored", int'(halted), 1);
    chk("halt_valid", int'(phase_valid), 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("halt_reset", int'(halted), 0);
    chk("halt_reset_count", int'(instr_count), 0);

    // Counter wrap on the 16th instruction with a 4-bit counter.
    begin
      int dones;
      dones = 0;
      exec_pulse();
      for (int i = 0; i < 200 && dones < 16; i++) begin
        tick();
        if (instr_done) begin
          dones++;
          if (dones == 15) chk("cnt_at_15", int'(instr_count), 15);
        end
      end
      chk("cnt_done_pulses", dones, 16);
      chk("cnt_wrapped", int'(instr_count), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
